tone_meter: RTL and testbench
=============================

TONE_METER -- requirements
Module: tone_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 20, giving the width of the phase-length counters.
REQ-002 SHALL have parameter TIMEOUT, default 1000000, giving the maximum clk cycles without a tone edge; legal range 2..2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  measurement enable, synchronous to clk.
REQ-006 SHALL have port tone_in  input  1  square wave (e.g. a divided clock), asynchronous to clk.
REQ-007 SHALL have port high_len  output  CNT_W  clk cycles of the last completed high phase.
REQ-008 SHALL have port low_len  output  CNT_W  clk cycles of the last completed low phase.
REQ-009 SHALL have port period  output  CNT_W+1  high_len+low_len of the last completed period.
REQ-010 SHALL have port meas_valid  output  1  one-cycle pulse when period and the lengths update.
REQ-011 SHALL have port locked  output  1  two consecutive equal periods measured.
REQ-012 SHALL have port timeout  output  1  sticky flag: TIMEOUT cycles passed without an edge.

Function
REQ-013 SHALL pass tone_in through a 2-flop synchronizer plus one history flop; an edge is detected when sync output differs from history (3 clk cycles of latency from a tone_in change).
REQ-014 SHALL implement states IDLE, WAIT_EDGE, MEAS_FIRST, MEAS.
REQ-015 SHALL be in IDLE while en=0; IDLE->WAIT_EDGE when en=1.
REQ-016 SHALL clear the phase counter in WAIT_EDGE; on the first detected edge go to MEAS_FIRST (that partial phase is discarded).
REQ-017 SHALL count cnt from 0 and increment it every cycle in MEAS_FIRST/MEAS; on a detected edge the phase length is cnt+1 and cnt returns to 0 in the same cycle.
REQ-018 SHALL, on a falling edge, capture the length into an internal high register; on a rising edge, capture it into an internal low register.
REQ-019 SHALL go MEAS_FIRST->MEAS when both a high and a low length have been captured since leaving WAIT_EDGE.
REQ-020 SHALL, on each rising edge detected in MEAS, update high_len, low_len, period=high+low (zero-extended, no overflow) and pulse meas_valid for exactly one cycle.
REQ-021 SHALL set locked when a meas_valid period equals the previous meas_valid period exactly; SHALL clear locked when they differ.
REQ-022 SHALL, when cnt reaches TIMEOUT-1 with no edge in MEAS_FIRST/MEAS, set timeout, clear locked, discard the history of partial lengths and go to WAIT_EDGE; cnt SHALL never wrap.
REQ-023 SHALL clear timeout on the next meas_valid pulse.
REQ-024 SHALL, when en falls in any state, go to IDLE the next cycle, suppress meas_valid in that cycle, clear locked, and hold high_len/low_len/period/timeout.
REQ-025 SHALL give meas_valid priority over timeout if both occur in one cycle; the edge wins and timeout is not set.

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, cnt, synchronizer and history flops, high_len, low_len, period, meas_valid, locked and timeout to 0, independent of clk.
REQ-027 SHALL, when rst is asserted in the middle of a measurement, abandon it with no meas_valid; after release, measurement restarts from WAIT_EDGE as in REQ-015/016.

Verification
REQ-028 SHALL cover: rst=0 asynchronously with clk stopped -> all outputs 0 immediately.
REQ-029 SHALL cover: en=1, tone_in 500 high/500 low clk cycles -> first meas_valid gives high_len=500, low_len=500, period=1000; next meas_valid gives locked=1.
REQ-030 SHALL cover: duty 300 high/700 low -> high_len=300, low_len=700, period=1000, locked after the second equal period.
REQ-031 SHALL cover: TIMEOUT=2000, tone_in held constant after lock -> timeout=1 and locked=0 exactly 2000 cycles after the last edge; tone resumes -> timeout clears on the next meas_valid.
REQ-032 SHALL cover: en dropped mid-phase -> no meas_valid, locked=0, lengths hold; en raised -> the first partial phase is discarded and a correct period is reported.
REQ-033 SHALL cover: rst pulsed mid-high-phase -> all outputs 0, then the correct measurement follows after release.

Source files
------------

// File: rtl/tone_meter.sv
`default_nettype none
// ============================================================================
// Module   : tone_meter
// Brief    : Measures high, low and period lengths of an asynchronous tone in clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tone_meter #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tone_in,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_EDGE  = 2'd1,
    MEAS_FIRST = 2'd2,
    MEAS       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2, r_hist;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_high, w_high_nxt;
  logic             r_have_high, w_have_high_nxt;
  logic             r_have_low, w_have_low_nxt;
  logic [CNT_W-1:0] r_high_len, w_high_len_nxt;
  logic [CNT_W-1:0] r_low_len, w_low_len_nxt;
  logic [CNT_W:0]   r_period, w_period_nxt;
  logic             r_meas_valid, w_meas_valid_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic             w_edge, w_rise, w_fall;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W:0]   w_sum;

  // Edge seen one flop after the two-stage synchronizer.
  assign w_edge = r_sync2 ^ r_hist;
  assign w_rise = r_sync2 & ~r_hist;
  assign w_fall = ~r_sync2 & r_hist;
  assign w_len  = r_cnt + C_CNT_ONE;
  assign w_sum  = {1'b0, r_high} + {1'b0, w_len};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= tone_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_high_nxt       = r_high;
    w_have_high_nxt  = r_have_high;
    w_have_low_nxt   = r_have_low;
    w_high_len_nxt   = r_high_len;
    w_low_len_nxt    = r_low_len;
    w_period_nxt     = r_period;
    w_meas_valid_nxt = 1'b0;
    w_locked_nxt     = r_locked;
    w_timeout_nxt    = r_timeout;

    if (!en) begin
      // Results and the sticky timeout survive a disable; only lock is dropped.
      w_state_nxt  = IDLE;
      w_cnt_nxt    = '0;
      w_locked_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          w_cnt_nxt = '0;
          if (w_edge) begin
            w_state_nxt     = MEAS_FIRST;
            w_have_high_nxt = 1'b0;
            w_have_low_nxt  = 1'b0;
          end
        end
        MEAS_FIRST, MEAS: begin
          if (w_edge) begin
            w_cnt_nxt = '0;
            if (w_fall) begin
              w_high_nxt      = w_len;
              w_have_high_nxt = 1'b1;
            end else begin
              w_have_low_nxt  = 1'b1;
            end
            if (r_state == MEAS_FIRST) begin
              if (w_have_high_nxt && w_have_low_nxt) begin
                w_state_nxt = MEAS;
              end
            end else if (w_rise) begin
              w_high_len_nxt   = r_high;
              w_low_len_nxt    = w_len;
              w_period_nxt     = w_sum;
              w_meas_valid_nxt = 1'b1;
              w_locked_nxt     = (w_sum == r_period);
              w_timeout_nxt    = 1'b0;
            end
          end else if (r_cnt == C_CNT_LAST) begin
            // Tone lost: stop before the counter could wrap and re-acquire.
            w_cnt_nxt       = '0;
            w_state_nxt     = WAIT_EDGE;
            w_have_high_nxt = 1'b0;
            w_have_low_nxt  = 1'b0;
            w_timeout_nxt   = 1'b1;
            w_locked_nxt    = 1'b0;
          end else begin
            w_cnt_nxt = w_len;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_high       <= '0;
      r_have_high  <= 1'b0;
      r_have_low   <= 1'b0;
      r_high_len   <= '0;
      r_low_len    <= '0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_high       <= w_high_nxt;
      r_have_high  <= w_have_high_nxt;
      r_have_low   <= w_have_low_nxt;
      r_high_len   <= w_high_len_nxt;
      r_low_len    <= w_low_len_nxt;
      r_period     <= w_period_nxt;
      r_meas_valid <= w_meas_valid_nxt;
      r_locked     <= w_locked_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign high_len   = r_high_len;
  assign low_len    = r_low_len;
  assign period     = r_period;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_tone_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_meter
// Brief    : Self-checking bench for tone_meter against an edge-timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_meter;

  localparam int CNT_W   = 12;
  localparam int TIMEOUT = 2000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             tone_in = 1'b0;
  logic [CNT_W-1:0] high_len, low_len;
  logic [CNT_W:0]   period;
  logic             meas_valid, locked, timeout;

  tone_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tone_in    (tone_in),
    .high_len   (high_len),
    .low_len    (low_len),
    .period     (period),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  int     n_vec = 0;
  int     n_err = 0;
  bit     clk_run = 0, mon_on = 0, tone_run = 0;
  int     hi_cyc = 500, lo_cyc = 500, ph_cnt = 0;
  longint cyc = 0, tog_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Tone generator: hi_cyc cycles high, lo_cyc cycles low, frozen while tone_run=0.
  initial forever begin
    @(posedge clk); #1;
    if (tone_run) begin
      ph_cnt++;
      if (ph_cnt >= (tone_in ? hi_cyc : lo_cyc)) begin
        tone_in = ~tone_in;
        ph_cnt  = 0;
        tog_cyc = cyc;
      end
    end
  end

  // Reference model: timestamps of detected edges since arming.
  bit               p1, p2, p3, armed, ev, rise;
  longint           mn, hi_l, lo_l;
  longint           et[$];
  int               ne;
  logic [CNT_W-1:0] m_hi, m_lo;
  logic [CNT_W:0]   m_per;
  bit               m_mv, m_lock, m_to;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1 = 0; p2 = 0; p3 = 0; armed = 0; ne = 0; mn = 0;
      et.delete();
      m_hi = '0; m_lo = '0; m_per = '0; m_mv = 0; m_lock = 0; m_to = 0;
    end else begin
      mn++;
      ev   = (p2 != p3);
      rise = p2;
      m_mv = 0;
      if (!en) begin
        armed  = 0;
        m_lock = 0;
      end else if (!armed) begin
        armed = 1;
        ne    = 0;
        et.delete();
      end else if (ev) begin
        et.push_back(mn);
        ne++;
        if (et.size() > 3) void'(et.pop_front());
        // Report on a rising edge once both a high and a low phase were seen earlier.
        if (rise && ne >= 4) begin
          hi_l   = et[1] - et[0];
          lo_l   = et[2] - et[1];
          m_lock = ((hi_l + lo_l) == longint'(m_per));
          m_hi   = CNT_W'(hi_l);
          m_lo   = CNT_W'(lo_l);
          m_per  = (CNT_W+1)'(hi_l + lo_l);
          m_mv   = 1;
          m_to   = 0;
        end
      end else if (et.size() > 0 && (mn - et[et.size()-1]) == TIMEOUT) begin
        m_to   = 1;
        m_lock = 0;
        ne     = 0;
        et.delete();
      end
      p3 = p2; p2 = p1; p1 = tone_in;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("meas_valid", meas_valid, m_mv);
      chk("high_len", high_len, m_hi);
      chk("low_len", low_len, m_lo);
      chk("period", period, m_per);
      chk("locked", locked, m_lock);
      chk("timeout", timeout, m_to);
    end
  end

  task automatic wait_mv(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (meas_valid === 1'b1) return;
    end
    chk("mv_wait", meas_valid, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hl"}, high_len, 0);
    chk({tag, "_ll"}, low_len, 0);
    chk({tag, "_per"}, period, 0);
    chk({tag, "_mv"}, meas_valid, 0);
    chk({tag, "_lock"}, locked, 0);
    chk({tag, "_to"}, timeout, 0);
  endtask

  task automatic chk_meas(input string tag, input int hi, input int lo);
    chk({tag, "_hl"}, high_len, hi);
    chk({tag, "_ll"}, low_len, lo);
    chk({tag, "_per"}, period, hi + lo);
  endtask

  initial begin
    bit saw_mv;

    // Asynchronous reset with the clock stopped.
    #5 rst = 1'b0;
    #1 chk_zero("rst_async");
    mon_on  = 1;
    clk_run = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // 500/500 tone.
    en = 1'b1; hi_cyc = 500; lo_cyc = 500; tone_run = 1;
    wait_mv(5000);
    chk_meas("sq500", 500, 500);
    chk("sq500_lock_first", locked, 0);
    wait_mv(1100);
    chk_meas("sq500b", 500, 500);
    chk("sq500_lock", locked, 1);

    // 30% duty cycle.
    hi_cyc = 300; lo_cyc = 700;
    repeat (3000) @(negedge clk);
    wait_mv(1100);
    chk_meas("duty30", 300, 700);
    chk("duty30_lock", locked, 1);

    // Tone stops right after a rising edge: timeout exactly TIMEOUT cycles after the edge.
    tone_run = 0;
    for (int i = 0; i < TIMEOUT + 100 && timeout !== 1'b1; i++) @(negedge clk);
    chk("to_set", timeout, 1);
    chk("to_delay", cyc - tog_cyc, TIMEOUT + 3);
    chk("to_unlock", locked, 0);
    tone_run = 1;
    wait_mv(3500);
    chk("to_clear", timeout, 0);
    chk_meas("to_resume", 300, 700);

    // en dropped mid-high phase.
    wait_mv(1100);
    repeat (150) @(posedge clk);
    #1 en = 1'b0;
    saw_mv = 0;
    repeat (700) begin
      @(negedge clk);
      saw_mv |= meas_valid;
    end
    chk("en_off_nomv", saw_mv, 0);
    chk("en_off_unlock", locked, 0);
    chk_meas("en_off_hold", 300, 700);
    @(posedge clk); #1 en = 1'b1;
    wait_mv(3500);
    chk_meas("en_back", 300, 700);

    // Reset pulsed in the middle of a high phase.
    wait_mv(1100);
    repeat (100) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_zero("rst_mid");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    wait_mv(3500);
    chk_meas("rst_after", 300, 700);
    chk("rst_after_lock", locked, 0);

    // Longest phase equal to TIMEOUT: the edge must win over the timeout.
    hi_cyc = TIMEOUT; lo_cyc = TIMEOUT - 1;
    wait_mv(8200);
    wait_mv(4100);
    chk_meas("edge_wins", TIMEOUT, TIMEOUT - 1);
    chk("edge_wins_to", timeout, 0);

    // Random tones with occasional enable glitches.
    for (int r = 0; r < 5; r++) begin
      hi_cyc = $urandom_range(2, 800);
      lo_cyc = $urandom_range(2, 800);
      repeat ($urandom_range(2500, 3500)) begin
        @(posedge clk); #1;
        if ($urandom_range(0, 999) == 0) en = ~en;
      end
      en = 1'b1;
    end

    // Random tone interrupted long enough to time out, then resumed.
    hi_cyc = $urandom_range(2, 400);
    lo_cyc = $urandom_range(2, 400);
    repeat (2000) @(posedge clk);
    tone_run = 0;
    repeat (2500) @(posedge clk);
    tone_run = 1;
    repeat (3000) @(posedge clk);

    @(negedge clk);
    mon_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
